a_secuenciador_banco: RTL

Multi-cycle execution sequencer that drives the 32×32 register bank from the other side of its interface. It accepts one decoded instruction at a time over a valid/ready handshake and issues the two register-read addresses. It then computes an ALU result or performs a memory LOAD/SAVE, and writes back through the bank's write port (`enable_w`, `write_data`, `data`). It sits between instruction decode and the register bank/data memory.

---
 rtl/a_secuenciador_banco.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/a_secuenciador_banco.sv
`default_nettype none
// ============================================================================
// Module      : a_secuenciador_banco
// Description : Multi-cycle execution sequencer sitting between instruction
//               decode and the 32x32 register bank / data memory. Accepts one
//               decoded instruction per valid/ready handshake, issues the two
//               bank read addresses, executes an ALU op or a LOAD/SAVE, and
//               writes back through the bank write port.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               in_valid/in_ready        - instruction handshake
//               in_op/in_rd/in_rs1/in_rs2/in_imm - decoded instruction fields
//               rf_read_data1/2, rf_out_d1/2     - bank read address / data
//               rf_write_data, rf_data, rf_enable_w - bank write port
//               mem_req/we/addr/wdata/rdata/ack  - data memory port
//               done, err, retired       - completion pulse, illegal flag, count
// Revision    : 1.0 - initial release
// ============================================================================
module a_secuenciador_banco #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int IMM_W   = 12,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_op,
    input  logic [RADDR_W-1:0] in_rd,
    input  logic [RADDR_W-1:0] in_rs1,
    input  logic [RADDR_W-1:0] in_rs2,
    input  logic [IMM_W-1:0]   in_imm,
    output logic [RADDR_W-1:0] rf_read_data1,
    output logic [RADDR_W-1:0] rf_read_data2,
    input  logic [DATA_W-1:0]  rf_out_d1,
    input  logic [DATA_W-1:0]  rf_out_d2,
    output logic [RADDR_W-1:0] rf_write_data,
    output logic [DATA_W-1:0]  rf_data,
    output logic               rf_enable_w,
    output logic               mem_req,
    output logic               mem_we,
    output logic [DATA_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata,
    input  logic               mem_ack,
    output logic               done,
    output logic               err,
    output logic [CNT_W-1:0]   retired
);

    localparam logic [2:0] c_OP_NOP  = 3'd0;
    localparam logic [2:0] c_OP_LOAD = 3'd1;
    localparam logic [2:0] c_OP_SAVE = 3'd2;
    localparam logic [2:0] c_OP_ADD  = 3'd3;
    localparam logic [2:0] c_OP_AND  = 3'd4;
    localparam logic [2:0] c_OP_OR   = 3'd5;
    localparam logic [2:0] c_OP_SUB  = 3'd6;
    localparam logic [2:0] c_OP_ILL  = 3'd7;

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_EXEC = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4
    } state_t;

    state_t             r_state;
    logic [2:0]         r_op;
    logic [RADDR_W-1:0] r_rd;
    logic [IMM_W-1:0]   r_imm;
    logic [DATA_W-1:0]  r_opa;
    logic [DATA_W-1:0]  r_opb;

    logic [DATA_W-1:0]  w_alu;
    logic [DATA_W-1:0]  w_imm_ext;
    logic               w_is_alu;
    logic               w_is_mem;
    logic               w_writes;

    assign w_imm_ext = {{(DATA_W-IMM_W){r_imm[IMM_W-1]}}, r_imm};
    assign w_is_alu  = (r_op == c_OP_ADD) || (r_op == c_OP_AND) ||
                       (r_op == c_OP_OR)  || (r_op == c_OP_SUB);
    assign w_is_mem  = (r_op == c_OP_LOAD) || (r_op == c_OP_SAVE);
    // r0 is the fixed "madre" register: never written.
    assign w_writes  = (w_is_alu || (r_op == c_OP_LOAD)) && (r_rd != '0);

    always_comb begin
        w_alu = '0;
        case (r_op)
            c_OP_ADD: w_alu = r_opa + r_opb;
            c_OP_AND: w_alu = r_opa & r_opb;
            c_OP_OR:  w_alu = r_opa | r_opb;
            c_OP_SUB: w_alu = r_opa - r_opb;
            default:  w_alu = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_op          <= c_OP_NOP;
            r_rd          <= '0;
            r_imm         <= '0;
            r_opa         <= '0;
            r_opb         <= '0;
            in_ready      <= 1'b1;
            rf_read_data1 <= '0;
            rf_read_data2 <= '0;
            rf_write_data <= '0;
            rf_data       <= '0;
            rf_enable_w   <= 1'b0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            done          <= 1'b0;
            err           <= 1'b0;
            retired       <= '0;
        end else begin
            // Single-cycle pulses default low; raised only on entry to WB.
            done        <= 1'b0;
            err         <= 1'b0;
            rf_enable_w <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        r_op          <= in_op;
                        r_rd          <= in_rd;
                        r_imm         <= in_imm;
                        rf_read_data1 <= in_rs1;
                        rf_read_data2 <= in_rs2;
                        in_ready      <= 1'b0;
                        r_state       <= S_READ;
                    end
                end

                S_READ: begin
                    // Bank read path is combinational from the addresses.
                    r_opa   <= rf_out_d1;
                    r_opb   <= rf_out_d2;
                    r_state <= S_EXEC;
                end

                S_EXEC: begin
                    if (w_is_mem) begin
                        mem_addr  <= r_opa + w_imm_ext;
                        mem_wdata <= r_opb;
                        mem_we    <= (r_op == c_OP_SAVE);
                        mem_req   <= 1'b1;
                        r_state   <= S_MEM;
                    end else begin
                        // Write port is loaded together with the enable so
                        // address/data are stable across the whole pulse.
                        if (w_is_alu) begin
                            rf_write_data <= r_rd;
                            rf_data       <= w_alu;
                        end
                        done        <= 1'b1;
                        err         <= (r_op == c_OP_ILL);
                        rf_enable_w <= w_writes;
                        r_state     <= S_WB;
                    end
                end

                S_MEM: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (r_op == c_OP_LOAD) begin
                            rf_write_data <= r_rd;
                            rf_data       <= mem_rdata;
                        end
                        done        <= 1'b1;
                        rf_enable_w <= w_writes;
                        r_state     <= S_WB;
                    end
                end

                S_WB: begin
                    retired  <= retired + c_CNT_ONE;
                    in_ready <= 1'b1;
                    r_state  <= S_IDLE;
                end

                default: begin
                    in_ready <= 1'b1;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
